// File: rtl/qdec_last_sig_coeff_fsm.sv
// qdec_last_sig_coeff_fsm
// Decodes last_sig_coeff_{x,y}_prefix (context coded, truncated unary) and
// their bypass suffixes for one transform block, then rebuilds
// LastSignificantCoeffX/Y. One bin request is in flight at a time.
module qdec_last_sig_coeff_fsm #(
  parameter logic [9:0] CTX_BASE_LAST_X = 10'd120,
  parameter logic [9:0] CTX_BASE_LAST_Y = 10'd138
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       last_start,
  input  logic [2:0] log2TrafoSize,
  input  logic [1:0] cIdx,
  input  logic [1:0] scanIdx,
  output logic [9:0] ctx_last_addr,
  output logic       ctx_last_addr_vld,
  output logic       dec_run_last,
  input  logic       dec_rdy,
  output logic       EPMode_last,
  input  logic       ruiBin,
  input  logic       ruiBin_vld,
  output logic [4:0] last_x,
  output logic [4:0] last_y,
  output logic       last_done_intr
);

  typedef enum logic [2:0] {
    IDLE, X_PREFIX, Y_PREFIX, X_SUFFIX, Y_SUFFIX, FINISH, DONE
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] log2_q, log2_d;
  logic       chroma_q, chroma_d;
  logic       swap_q, swap_d;
  logic [3:0] xpre_q, xpre_d, ypre_q, ypre_d;
  logic [2:0] xsuf_q, xsuf_d, ysuf_q, ysuf_d;
  logic [1:0] sufcnt_q, sufcnt_d;
  logic       outst_q, outst_d;
  logic [9:0] ctx_addr_q, ctx_addr_d;
  logic       ctx_vld_q, ctx_vld_d;
  logic       dec_run_q, dec_run_d;
  logic       ep_q, ep_d;
  logic [4:0] last_x_q, last_x_d, last_y_q, last_y_d;
  logic       done_q, done_d;

  logic       consume, issue, in_prefix, in_suffix, prefix_end;
  logic [3:0] cur_pre, pre_inc, cmax, l4;
  logic [3:0] luma_off, luma_shift, ctx_off, ctx_shift;
  logic [9:0] ctx_base, ctx_addr_calc;
  logic [4:0] x_val, y_val;

  // Suffix length in bins for a prefix above 3: (prefix>>1) - 1, range 1..3.
  function automatic logic [1:0] suf_len(input logic [3:0] pre);
    logic [2:0] t;
    t = pre[3:1] - 3'd1;
    return t[1:0];
  endfunction

  // Value rebuilt from prefix and suffix.
  function automatic logic [4:0] recon(input logic [3:0] pre, input logic [2:0] suf);
    logic [2:0] sh;
    logic [4:0] base;
    sh   = pre[3:1] - 3'd1;
    base = (pre[0] ? 5'd3 : 5'd2) << sh;
    if (pre > 4'd3) return base + {2'b00, suf};
    else            return {1'b0, pre};
  endfunction

  // Next-state, request generation and reconstruction.
  always_comb begin
    state_d   = state_q;
    log2_d    = log2_q;
    chroma_d  = chroma_q;
    swap_d    = swap_q;
    xpre_d    = xpre_q;
    ypre_d    = ypre_q;
    xsuf_d    = xsuf_q;
    ysuf_d    = ysuf_q;
    sufcnt_d  = sufcnt_q;
    outst_d   = outst_q;
    ctx_addr_d = 10'd0;
    ctx_vld_d = 1'b0;
    dec_run_d = 1'b0;
    ep_d      = 1'b0;
    last_x_d  = last_x_q;
    last_y_d  = last_y_q;
    done_d    = 1'b0;

    in_prefix  = (state_q == X_PREFIX) || (state_q == Y_PREFIX);
    in_suffix  = (state_q == X_SUFFIX) || (state_q == Y_SUFFIX);
    consume    = outst_q && ruiBin_vld;
    issue      = (in_prefix || in_suffix) && !outst_q && dec_rdy;
    cur_pre    = (state_q == Y_PREFIX) ? ypre_q : xpre_q;
    pre_inc    = cur_pre + 4'd1;
    cmax       = {log2_q, 1'b0} - 4'd1;
    prefix_end = !ruiBin || (pre_inc == cmax);

    // Context index: offset by block size, then binIdx scaled down by shift.
    l4         = {1'b0, log2_q};
    luma_off   = (l4 - 4'd2) * 4'd3 + ((l4 - 4'd1) >> 2);
    luma_shift = (l4 + 4'd1) >> 2;
    ctx_off    = chroma_q ? 4'd15 : luma_off;
    ctx_shift  = chroma_q ? (l4 - 4'd2) : luma_shift;
    ctx_base   = (state_q == Y_PREFIX) ? CTX_BASE_LAST_Y : CTX_BASE_LAST_X;
    ctx_addr_calc = ctx_base + {6'd0, ctx_off} + {6'd0, cur_pre >> ctx_shift};

    x_val = recon(xpre_q, xsuf_q);
    y_val = recon(ypre_q, ysuf_q);

    if (consume) outst_d = 1'b0;
    if (issue) begin
      outst_d   = 1'b1;
      dec_run_d = 1'b1;
      if (in_prefix) begin
        ctx_vld_d  = 1'b1;
        ctx_addr_d = ctx_addr_calc;
      end else begin
        ep_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (last_start) begin
          state_d  = X_PREFIX;
          log2_d   = (log2TrafoSize < 3'd2) ? 3'd2 :
                     (log2TrafoSize > 3'd5) ? 3'd5 : log2TrafoSize;
          chroma_d = |cIdx;
          swap_d   = (scanIdx == 2'd2);
          xpre_d   = 4'd0;
          ypre_d   = 4'd0;
          xsuf_d   = 3'd0;
          ysuf_d   = 3'd0;
          sufcnt_d = 2'd0;
          outst_d  = 1'b0;
        end
      end
      X_PREFIX: begin
        if (consume) begin
          if (ruiBin) xpre_d = pre_inc;
          if (prefix_end) state_d = Y_PREFIX;
        end
      end
      Y_PREFIX: begin
        if (consume) begin
          if (ruiBin) ypre_d = pre_inc;
          if (prefix_end) begin
            if (xpre_q > 4'd3) begin
              state_d  = X_SUFFIX;
              sufcnt_d = suf_len(xpre_q);
            end else if (ypre_d > 4'd3) begin
              state_d  = Y_SUFFIX;
              sufcnt_d = suf_len(ypre_d);
            end else begin
              state_d = FINISH;
            end
          end
        end
      end
      X_SUFFIX: begin
        if (consume) begin
          xsuf_d   = {xsuf_q[1:0], ruiBin};
          sufcnt_d = sufcnt_q - 2'd1;
          if (sufcnt_q == 2'd1) begin
            if (ypre_q > 4'd3) begin
              state_d  = Y_SUFFIX;
              sufcnt_d = suf_len(ypre_q);
            end else begin
              state_d = FINISH;
            end
          end
        end
      end
      Y_SUFFIX: begin
        if (consume) begin
          ysuf_d   = {ysuf_q[1:0], ruiBin};
          sufcnt_d = sufcnt_q - 2'd1;
          if (sufcnt_q == 2'd1) state_d = FINISH;
        end
      end
      FINISH: begin
        last_x_d = swap_q ? y_val : x_val;
        last_y_d = swap_q ? x_val : y_val;
        done_d   = 1'b1;
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      log2_q     <= 3'd2;
      chroma_q   <= 1'b0;
      swap_q     <= 1'b0;
      xpre_q     <= 4'd0;
      ypre_q     <= 4'd0;
      xsuf_q     <= 3'd0;
      ysuf_q     <= 3'd0;
      sufcnt_q   <= 2'd0;
      outst_q    <= 1'b0;
      ctx_addr_q <= 10'd0;
      ctx_vld_q  <= 1'b0;
      dec_run_q  <= 1'b0;
      ep_q       <= 1'b0;
      last_x_q   <= 5'd0;
      last_y_q   <= 5'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      log2_q     <= log2_d;
      chroma_q   <= chroma_d;
      swap_q     <= swap_d;
      xpre_q     <= xpre_d;
      ypre_q     <= ypre_d;
      xsuf_q     <= xsuf_d;
      ysuf_q     <= ysuf_d;
      sufcnt_q   <= sufcnt_d;
      outst_q    <= outst_d;
      ctx_addr_q <= ctx_addr_d;
      ctx_vld_q  <= ctx_vld_d;
      dec_run_q  <= dec_run_d;
      ep_q       <= ep_d;
      last_x_q   <= last_x_d;
      last_y_q   <= last_y_d;
      done_q     <= done_d;
    end
  end

  assign ctx_last_addr     = ctx_addr_q;
  assign ctx_last_addr_vld = ctx_vld_q;
  assign dec_run_last      = dec_run_q;
  assign EPMode_last       = ep_q;
  assign last_x            = last_x_q;
  assign last_y            = last_y_q;
  assign last_done_intr    = done_q;

endmodule

// File: tb/tb_qdec_last_sig_coeff_fsm.sv
// Bench for qdec_last_sig_coeff_fsm: a decoder responder feeds scripted bins,
// a scoreboard of expected requests is checked as the DUT issues them.
module tb_qdec_last_sig_coeff_fsm;

  logic       clk = 1'b0;
  logic       rst, last_start, dec_rdy, ruiBin, ruiBin_vld;
  logic [2:0] log2TrafoSize;
  logic [1:0] cIdx, scanIdx;
  logic [9:0] ctx_last_addr;
  logic       ctx_last_addr_vld, dec_run_last, EPMode_last, last_done_intr;
  logic [4:0] last_x, last_y;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [9:0] addr;
    logic       ep;
  } req_t;

  req_t exp_q[$];
  bit   bin_q[$];

  qdec_last_sig_coeff_fsm dut (
    .clk(clk), .rst(rst), .last_start(last_start),
    .log2TrafoSize(log2TrafoSize), .cIdx(cIdx), .scanIdx(scanIdx),
    .ctx_last_addr(ctx_last_addr), .ctx_last_addr_vld(ctx_last_addr_vld),
    .dec_run_last(dec_run_last), .dec_rdy(dec_rdy), .EPMode_last(EPMode_last),
    .ruiBin(ruiBin), .ruiBin_vld(ruiBin_vld),
    .last_x(last_x), .last_y(last_y), .last_done_intr(last_done_intr)
  );

  always #5 clk = ~clk;

  task automatic push_ctx(input logic [9:0] a, input bit b);
    exp_q.push_back('{addr: a, ep: 1'b0});
    bin_q.push_back(b);
  endtask

  task automatic push_ep(input bit b);
    exp_q.push_back('{addr: 10'd0, ep: 1'b1});
    bin_q.push_back(b);
  endtask

  // Drives one block through the DUT; options add a dec_rdy stall window,
  // a stray ruiBin_vld inside it, and a last_start pulse while busy.
  task automatic run_block(input string name, input logic [2:0] l2, input logic [1:0] ci,
                           input logic [1:0] sc, input logic [4:0] ex, input logic [4:0] ey,
                           input int stall, input bit spurious, input bit busy_start);
    int   done_cnt = 0;
    int   tail = 0;
    int   wait_cnt = 0;
    bit   pending = 0;
    bit   cur_bin = 0;
    req_t r;
    @(negedge clk);
    log2TrafoSize = l2; cIdx = ci; scanIdx = sc;
    last_start = 1'b1;
    dec_rdy = (stall == 0);
    @(negedge clk);
    last_start = 1'b0;
    log2TrafoSize = ~l2; cIdx = ~ci; scanIdx = ~sc;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc < stall) begin
        n_cmp++;
        if (dec_run_last !== 1'b0) begin
          n_bad++;
          $display("FAIL %s stall: dec_run_last=%b required 0 (cycle %0d)", name, dec_run_last, cyc);
        end
      end
      if (dec_run_last === 1'b1) begin
        n_cmp++;
        if (pending) begin
          n_bad++;
          $display("FAIL %s overlap: request while one outstanding", name);
        end
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL %s extra_req: addr=%0d ep=%b required none", name, ctx_last_addr, EPMode_last);
        end else begin
          r = exp_q.pop_front();
          cur_bin = bin_q.pop_front();
          if (EPMode_last !== r.ep || ctx_last_addr_vld !== !r.ep ||
              (!r.ep && ctx_last_addr !== r.addr)) begin
            n_bad++;
            $display("FAIL %s req: addr=%0d vld=%b ep=%b required addr=%0d vld=%b ep=%b",
                     name, ctx_last_addr, ctx_last_addr_vld, EPMode_last, r.addr, !r.ep, r.ep);
          end else begin
            $display("%s req ok: addr=%0d ep=%b bin=%b", name, ctx_last_addr, EPMode_last, cur_bin);
          end
          pending = 1;
          wait_cnt = $urandom_range(0, 2);
        end
      end
      if (last_done_intr === 1'b1) begin
        done_cnt++;
        n_cmp++;
        if (last_x !== ex || last_y !== ey) begin
          n_bad++;
          $display("FAIL %s result: x=%0d y=%0d required x=%0d y=%0d", name, last_x, last_y, ex, ey);
        end else begin
          $display("%s done: x=%0d y=%0d", name, last_x, last_y);
        end
      end
      if (done_cnt > 0) tail++;
      if (tail > 5) break;
      ruiBin_vld = 1'b0;
      ruiBin = 1'($urandom_range(0, 1));
      if (cyc < stall) begin
        dec_rdy = 1'b0;
        if (spurious && cyc == 3) begin
          ruiBin_vld = 1'b1;
          ruiBin = 1'b1;
        end
      end else begin
        dec_rdy = 1'b1;
      end
      if (pending) begin
        if (wait_cnt == 0) begin
          ruiBin_vld = 1'b1;
          ruiBin = cur_bin;
          pending = 0;
        end else begin
          wait_cnt--;
        end
      end
      if (busy_start && cyc == stall + 2) begin
        last_start = 1'b1;
        log2TrafoSize = 3'd5; cIdx = 2'd1; scanIdx = 2'd2;
      end else begin
        last_start = 1'b0;
      end
      @(negedge clk);
    end
    ruiBin_vld = 1'b0;
    last_start = 1'b0;
    n_cmp++;
    if (done_cnt != 1 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s end: done pulses=%0d left requests=%0d required 1 and 0",
               name, done_cnt, exp_q.size());
    end
    n_cmp++;
    if (last_x !== ex || last_y !== ey) begin
      n_bad++;
      $display("FAIL %s hold: x=%0d y=%0d required x=%0d y=%0d", name, last_x, last_y, ex, ey);
    end
    exp_q.delete();
    bin_q.delete();
  endtask

  task automatic check_outputs_zero(input string name);
    n_cmp++;
    if (ctx_last_addr !== 10'd0 || ctx_last_addr_vld !== 1'b0 || dec_run_last !== 1'b0 ||
        EPMode_last !== 1'b0 || last_x !== 5'd0 || last_y !== 5'd0 || last_done_intr !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: addr=%0d vld=%b run=%b ep=%b x=%0d y=%0d done=%b required all 0",
               name, ctx_last_addr, ctx_last_addr_vld, dec_run_last, EPMode_last,
               last_x, last_y, last_done_intr);
    end else begin
      $display("%s: outputs at reset values", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; last_start = 1'b0; dec_rdy = 1'b1; ruiBin = 1'b0; ruiBin_vld = 1'b0;
    log2TrafoSize = 3'd2; cIdx = 2'd0; scanIdx = 2'd0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_hold");
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset_release");
  endtask

  task automatic push_small_luma();
    push_ctx(10'd120, 1'b1); push_ctx(10'd121, 1'b0); push_ctx(10'd138, 1'b0);
  endtask

  task automatic test_small_luma();
    push_small_luma();
    run_block("small_luma", 3'd2, 2'd0, 2'd0, 5'd1, 5'd0, 0, 0, 0);
  endtask

  task automatic test_luma32_suffix();
    push_ctx(10'd130, 1); push_ctx(10'd130, 1); push_ctx(10'd131, 1);
    push_ctx(10'd131, 1); push_ctx(10'd132, 1); push_ctx(10'd132, 0);
    push_ctx(10'd148, 0);
    push_ep(1);
    run_block("luma32_suffix", 3'd5, 2'd0, 2'd0, 5'd7, 5'd0, 0, 0, 0);
  endtask

  task automatic test_truncated_prefix();
    push_ctx(10'd123, 1); push_ctx(10'd123, 1); push_ctx(10'd124, 1);
    push_ctx(10'd124, 1); push_ctx(10'd125, 1);
    push_ctx(10'd138 + 10'd3, 0);
    push_ep(0);
    run_block("truncated_prefix", 3'd3, 2'd0, 2'd0, 5'd6, 5'd0, 0, 0, 0);
  endtask

  task automatic test_chroma_vertical();
    push_ctx(10'd135, 0);
    push_ctx(10'd153, 1); push_ctx(10'd153, 1); push_ctx(10'd153, 0);
    run_block("chroma_vertical", 3'd4, 2'd1, 2'd2, 5'd2, 5'd0, 0, 0, 0);
  endtask

  // Largest prefix on both axes with multi-bin suffixes: x = 8*3+5, y = 2*2+1.
  task automatic test_max_both_suffix();
    push_ctx(10'd130, 1); push_ctx(10'd130, 1); push_ctx(10'd131, 1);
    push_ctx(10'd131, 1); push_ctx(10'd132, 1); push_ctx(10'd132, 1);
    push_ctx(10'd133, 1); push_ctx(10'd133, 1); push_ctx(10'd134, 1);
    push_ctx(10'd148, 1); push_ctx(10'd148, 1); push_ctx(10'd149, 1);
    push_ctx(10'd149, 1); push_ctx(10'd150, 0);
    push_ep(1); push_ep(0); push_ep(1);
    push_ep(1);
    run_block("max_both_suffix", 3'd5, 2'd0, 2'd0, 5'd29, 5'd5, 0, 0, 0);
  endtask

  // Out-of-range sizes clamp to 5 and 2.
  task automatic test_clamp();
    push_ctx(10'd130, 0);
    push_ctx(10'd148, 1); push_ctx(10'd148, 0);
    run_block("clamp_high", 3'd7, 2'd0, 2'd0, 5'd0, 5'd1, 0, 0, 0);
    push_ctx(10'd135, 1); push_ctx(10'd136, 1); push_ctx(10'd137, 1);
    push_ctx(10'd153, 0);
    run_block("clamp_low_chroma", 3'd1, 2'd2, 2'd1, 5'd3, 5'd0, 0, 0, 0);
  endtask

  task automatic test_stall_spurious_busy();
    push_small_luma();
    run_block("stall_spurious_busy", 3'd2, 2'd0, 2'd0, 5'd1, 5'd0, 10, 1, 1);
  endtask

  task automatic test_reset_mid();
    bit   found = 0;
    bit   b;
    req_t r;
    push_small_luma();
    @(negedge clk);
    log2TrafoSize = 3'd2; cIdx = 2'd0; scanIdx = 2'd0;
    last_start = 1'b1; dec_rdy = 1'b1;
    @(negedge clk);
    last_start = 1'b0;
    for (int cyc = 0; cyc < 100 && !found; cyc++) begin
      ruiBin_vld = 1'b0;
      if (dec_run_last === 1'b1 && exp_q.size() > 0) begin
        r = exp_q.pop_front();
        b = bin_q.pop_front();
        if (r.addr == 10'd138) begin
          found = 1;
        end else begin
          ruiBin_vld = 1'b1;
          ruiBin = b;
        end
      end
      if (!found) @(negedge clk);
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL reset_mid reach_y: y prefix request seen=%b required 1", found);
    end
    rst = 1'b1;
    ruiBin_vld = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset_mid_next_cycle");
    last_start = 1'b1;
    @(negedge clk);
    check_outputs_zero("reset_with_start");
    rst = 1'b0;
    last_start = 1'b0;
    ruiBin_vld = 1'b1;
    ruiBin = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      ruiBin_vld = 1'b0;
      n_cmp++;
      if (dec_run_last !== 1'b0 || last_done_intr !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_quiet: run=%b done=%b required 0 0", dec_run_last, last_done_intr);
      end
    end
    exp_q.delete();
    bin_q.delete();
    push_small_luma();
    run_block("after_reset_small_luma", 3'd2, 2'd0, 2'd0, 5'd1, 5'd0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    push_ctx(10'd135, 0); push_ctx(10'd153, 1); push_ctx(10'd153, 1); push_ctx(10'd153, 0);
    run_block("b2b_chroma", 3'd4, 2'd1, 2'd2, 5'd2, 5'd0, 0, 0, 0);
    push_small_luma();
    run_block("b2b_small_luma", 3'd2, 2'd0, 2'd0, 5'd1, 5'd0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_small_luma();
    test_luma32_suffix();
    test_truncated_prefix();
    test_chroma_vertical();
    test_max_both_suffix();
    test_clamp();
    test_stall_spurious_busy();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
